// File: rtl/halfband_sched_pkg.sv
// Shared definitions for the halfband coefficient scheduler: default
// coefficient set, bank-swap FSM states and parameter defaults.
package halfband_sched_pkg;

    localparam int WIDTH_DEF = 18;
    localparam int NCOEF_DEF = 8;

    localparam int DEF_COEF [8] = '{-348, 0, 3274, 0, -15925, 0, 78535, 131072};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_FILL
    } state_t;

    // Indices beyond the stored default set reset to zero.
    function automatic int default_coef(input int idx);
        return (idx >= 0 && idx < 8) ? DEF_COEF[idx] : 0;
    endfunction

endpackage

// File: rtl/halfband_strobe_gen.sv
// Sample-rate divider: free-running 0..DIV-1 counter with the sample strobe,
// the double-rate strobe and the halfband phase bit.
module halfband_strobe_gen #(
    parameter int DIV = 16
) (
    input  logic sys_clk,
    input  logic reset,
    output logic sam_clk_en,
    output logic sys_clk2_en,
    output logic phase
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             phase_reg;

    assign sam_clk_en  = (count_reg == CNT_W'(DIV - 1));
    assign sys_clk2_en = sam_clk_en || (count_reg == CNT_W'(DIV / 2 - 1));
    assign phase       = phase_reg;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (sam_clk_en) begin
            count_next = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            count_reg <= '0;
            phase_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (sys_clk2_en) begin
                phase_reg <= ~phase_reg;
            end
        end
    end

endmodule

// File: rtl/halfband_sched.sv
// Halfband filter coefficient scheduler: double-buffered coefficient bank
// swapped only on a sample boundary, followed by a pipeline-flush interval.
module halfband_sched
    import halfband_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NCOEF = NCOEF_DEF,
    parameter int DIV   = 16,
    parameter int FILL  = 5
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    output logic                   sam_clk_en,
    output logic                   sys_clk2_en,
    output logic                   phase,
    input  logic                   coef_wr_en,
    input  logic [2:0]             coef_addr,
    input  logic [WIDTH-1:0]       coef_data,
    input  logic                   coef_commit,
    output logic [NCOEF*WIDTH-1:0] coef_active,
    output logic                   commit_ack,
    output logic                   wr_err,
    output logic                   out_valid
);

    localparam int FILL_W = $clog2(FILL + 1);

    state_t            state_reg, state_next;
    logic [FILL_W-1:0] fill_cnt_reg, fill_cnt_next;
    logic              out_valid_reg, out_valid_next;
    logic              wr_err_reg, wr_err_next;
    logic              fill_done;
    logic              wr_allowed;

    logic [WIDTH-1:0] shadow_reg [NCOEF];
    logic [WIDTH-1:0] active_reg [NCOEF];

    halfband_strobe_gen #(
        .DIV(DIV)
    ) u_strobe (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sys_clk2_en(sys_clk2_en),
        .phase      (phase)
    );

    // The bank is frozen while a swap is pending so the snapshot is well defined.
    assign wr_allowed = coef_wr_en && (state_reg != ST_PENDING);

    always_comb begin
        state_next     = state_reg;
        fill_cnt_next  = '0;
        out_valid_next = out_valid_reg;
        commit_ack     = 1'b0;
        fill_done      = 1'b0;
        wr_err_next    = coef_wr_en && ((state_reg == ST_PENDING) || (int'(coef_addr) >= NCOEF));
        case (state_reg)
            ST_IDLE: begin
                if (coef_commit) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (sam_clk_en) begin
                    commit_ack     = 1'b1;
                    out_valid_next = 1'b0;
                    state_next     = ST_FILL;
                end
            end
            ST_FILL: begin
                if (coef_commit) begin
                    state_next = ST_PENDING;
                end else if (sys_clk2_en) begin
                    if (fill_cnt_reg == FILL_W'(FILL - 1)) begin
                        fill_done      = 1'b1;
                        out_valid_next = 1'b1;
                        state_next     = ST_IDLE;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + 1'b1;
                    end
                end else begin
                    fill_cnt_next = fill_cnt_reg;
                end
            end
            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_reg     <= ST_FILL;
            fill_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fill_cnt_reg  <= fill_cnt_next;
            out_valid_reg <= out_valid_next;
            wr_err_reg    <= wr_err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NCOEF; gi++) begin : g_bank
            localparam logic [WIDTH-1:0] DEF_VAL = WIDTH'(default_coef(gi));

            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    shadow_reg[gi] <= DEF_VAL;
                    active_reg[gi] <= DEF_VAL;
                end else begin
                    if (wr_allowed && (int'(coef_addr) == gi)) begin
                        shadow_reg[gi] <= coef_data;
                    end
                    if (commit_ack) begin
                        active_reg[gi] <= shadow_reg[gi];
                    end
                end
            end

            assign coef_active[gi*WIDTH +: WIDTH] = active_reg[gi];
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign wr_err    = wr_err_reg;

    logic unused_fill_done;
    assign unused_fill_done = fill_done;

endmodule

// File: tb/tb_halfband_sched.sv
// Randomised scoreboard bench for halfband_sched against a sample-level
// reference model, plus a few directed scenario checks.
module tb_halfband_sched;

    localparam int WIDTH = 18;
    localparam int NCOEF = 8;
    localparam int DIV   = 16;
    localparam int FILL  = 5;

    logic                   sys_clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   sam_clk_en;
    logic                   sys_clk2_en;
    logic                   phase;
    logic                   coef_wr_en = 1'b0;
    logic [2:0]             coef_addr = '0;
    logic [WIDTH-1:0]       coef_data = '0;
    logic                   coef_commit = 1'b0;
    logic [NCOEF*WIDTH-1:0] coef_active;
    logic                   commit_ack;
    logic                   wr_err;
    logic                   out_valid;

    halfband_sched #(
        .WIDTH(WIDTH),
        .NCOEF(NCOEF),
        .DIV  (DIV),
        .FILL (FILL)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .sam_clk_en (sam_clk_en),
        .sys_clk2_en(sys_clk2_en),
        .phase      (phase),
        .coef_wr_en (coef_wr_en),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_commit(coef_commit),
        .coef_active(coef_active),
        .commit_ack (commit_ack),
        .wr_err     (wr_err),
        .out_valid  (out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit                     known;
        bit                     sam;
        bit                     clk2;
        bit                     phase;
        bit                     ack;
        bit                     err;
        bit                     valid;
        logic [NCOEF*WIDTH-1:0] act;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   defs [NCOEF] = '{-348, 0, 3274, 0, -15925, 0, 78535, 131072};

    // Reference model: position within the sample period, mode 0=idle 1=pending 2=fill
    int               m_cnt = 0;
    int               m_phase = 0;
    int               m_mode = 2;
    int               m_fill_left = FILL;
    bit               m_valid = 1'b0;
    bit               m_err = 1'b0;
    bit               m_known = 1'b0;
    logic [WIDTH-1:0] m_shadow [NCOEF];
    logic [WIDTH-1:0] m_active [NCOEF];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input string name, input logic [NCOEF*WIDTH-1:0] act,
                             input logic [NCOEF*WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCOEF*WIDTH-1:0] default_bank();
        logic [NCOEF*WIDTH-1:0] p;
        for (int i = 0; i < NCOEF; i++) p[i*WIDTH +: WIDTH] = WIDTH'(defs[i]);
        return p;
    endfunction

    function automatic logic [NCOEF*WIDTH-1:0] model_bank();
        logic [NCOEF*WIDTH-1:0] p;
        for (int i = 0; i < NCOEF; i++) p[i*WIDTH +: WIDTH] = m_active[i];
        return p;
    endfunction

    // Drive one cycle of inputs, record what the DUT must show this cycle, advance the model.
    task automatic cyc(input bit r, input bit w, input int a, input int d, input bit c);
        exp_t e;
        bit   sam;
        bit   clk2;
        reset       = r;
        coef_wr_en  = w;
        coef_addr   = 3'(a);
        coef_data   = WIDTH'(d);
        coef_commit = c;
        sam  = (m_cnt == DIV - 1);
        clk2 = sam || (m_cnt == DIV / 2 - 1);
        e.known = m_known;
        e.sam   = sam;
        e.clk2  = clk2;
        e.phase = m_phase[0];
        e.ack   = (m_mode == 1) && sam;
        e.err   = m_err;
        e.valid = m_valid;
        e.act   = model_bank();
        sb.push_back(e);
        if (r) begin
            m_known     = 1'b1;
            m_cnt       = 0;
            m_phase     = 0;
            m_mode      = 2;
            m_fill_left = FILL;
            m_valid     = 1'b0;
            m_err       = 1'b0;
            for (int i = 0; i < NCOEF; i++) begin
                m_shadow[i] = WIDTH'(defs[i]);
                m_active[i] = WIDTH'(defs[i]);
            end
        end else begin
            m_err = w && (m_mode == 1 || a >= NCOEF);
            if (w && m_mode != 1 && a < NCOEF) m_shadow[a] = WIDTH'(d);
            case (m_mode)
                0: if (c) m_mode = 1;
                1: if (sam) begin
                    m_active    = m_shadow;
                    m_valid     = 1'b0;
                    m_mode      = 2;
                    m_fill_left = FILL;
                end
                default: begin
                    if (c) begin
                        m_mode = 1;
                    end else if (clk2) begin
                        m_fill_left--;
                        if (m_fill_left == 0) begin
                            m_mode  = 0;
                            m_valid = 1'b1;
                        end
                    end
                end
            endcase
            m_cnt   = (m_cnt + 1) % DIV;
            m_phase = m_phase ^ int'(clk2);
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic to_count(input int c);
        while (m_cnt != c) cyc(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic first_valid_after_reset();
        int first_valid;
        first_valid = -1;
        for (int t = 0; t < 50; t++) begin
            if (out_valid === 1'b1 && first_valid < 0) first_valid = t;
            cyc(1'b0, 1'b0, 0, 0, 1'b0);
        end
        check_int("first_valid_cycle", first_valid, 40);
    endtask

    always @(negedge sys_clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            if (mon_e.known) begin
                check_bit("sam_clk_en", sam_clk_en, mon_e.sam);
                check_bit("sys_clk2_en", sys_clk2_en, mon_e.clk2);
                check_bit("phase", phase, mon_e.phase);
                check_bit("commit_ack", commit_ack, mon_e.ack);
                check_bit("wr_err", wr_err, mon_e.err);
                check_bit("out_valid", out_valid, mon_e.valid);
                check_vec("coef_active", coef_active, mon_e.act);
            end
        end
    end

    initial begin
        int d;
        @(posedge sys_clk);
        #1;
        repeat (3) cyc(1'b1, 1'b0, 0, 0, 1'b0);
        first_valid_after_reset();

        // Commit a new tap 7 at count 3; the swap waits for count 15.
        to_count(1);
        cyc(1'b0, 1'b1, 7, 65536, 1'b0);
        to_count(3);
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        to_count(15);
        check_int("tap7_before_swap", int'(coef_active[7*WIDTH +: WIDTH]), 131072);
        check_bit("ack_at_count15", commit_ack, 1'b1);
        idle(1);
        check_int("tap7_after_swap", int'(coef_active[7*WIDTH +: WIDTH]), 65536);
        idle(60);

        // Write attempted while the swap is pending is rejected.
        to_count(4);
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        cyc(1'b0, 1'b1, 2, 100, 1'b0);
        check_bit("wr_err_pending", wr_err, 1'b1);
        idle(70);
        check_int("tap2_kept", int'(coef_active[2*WIDTH +: WIDTH]), 3274);

        // Commit on the wrap cycle lands one full sample later.
        to_count(15);
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        d = 0;
        while (commit_ack !== 1'b1 && d < 40) begin
            cyc(1'b0, 1'b0, 0, 0, 1'b0);
            d++;
        end
        check_int("commit_to_ack_cycles", d + 1, 16);
        idle(60);

        // Reset while pending discards the commit and restores defaults.
        to_count(5);
        cyc(1'b0, 1'b1, 0, 777, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b1);
        idle(3);
        repeat (2) cyc(1'b1, 1'b0, 0, 0, 1'b0);
        first_valid_after_reset();
        check_vec("bank_defaults_after_reset", coef_active, default_bank());

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 262143)),
                $urandom_range(0, 39) == 0);
        end
        idle(1);
        @(negedge sys_clk);
        #1;
        check_int("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/halfband_sched.md
HALFBAND_SCHED -- requirements
Module: halfband_sched

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 18, coefficient width (0s18)
- NCOEF, 8, unique coefficients
- DIV, 16, sys_clk cycles per input sample; even, >=4
- FILL, 5, sys_clk2_en strobes for the filter pipeline to flush
REQ-002 Ports SHALL be:
- sys_clk  in  1  single clock
- reset  in  1  synchronous, active-high
- sam_clk_en  out  1  one-cycle pulse per sample period
- sys_clk2_en  out  1  one-cycle pulse at twice the sample rate
- phase  out  1  halfband phase, toggles on each sys_clk2_en
- coef_wr_en  in  1  shadow-bank write strobe
- coef_addr  in  3  shadow-bank index
- coef_data  in  WIDTH  signed coefficient
- coef_commit  in  1  request a shadow-to-active swap
- coef_active  out  NCOEF*WIDTH  active bank; index i occupies bits [i*WIDTH +: WIDTH]
- commit_ack  out  1  one-cycle pulse when the swap occurs
- wr_err  out  1  one-cycle pulse when a write is rejected
- out_valid  out  1  filter output is trustworthy

Function
REQ-003 Divider: a free-running counter SHALL count 0..DIV-1 and wrap.
REQ-004 sam_clk_en SHALL be high only when count==DIV-1.
REQ-005 sys_clk2_en SHALL be high only when count==DIV/2-1 or count==DIV-1.
REQ-006 phase SHALL toggle on the same cycle sys_clk2_en is high; the toggle is visible the next cycle.
REQ-007 When coef_wr_en is high and the state is not PENDING, shadow[coef_addr] SHALL take coef_data on that edge.
REQ-008 Writes with coef_addr >= NCOEF SHALL be ignored and SHALL pulse wr_err.
REQ-009 A write in PENDING SHALL be ignored and SHALL pulse wr_err the next cycle.
REQ-010 The FSM states SHALL be IDLE, PENDING and FILL.
REQ-011 IDLE -> PENDING on coef_commit.
REQ-012 In PENDING, on the first cycle with count==DIV-1, the full shadow bank SHALL be copied to the active bank, commit_ack SHALL pulse in that cycle, and the state SHALL become FILL.
REQ-013 FILL SHALL drop out_valid, count FILL sys_clk2_en strobes, then go to IDLE and set out_valid.
REQ-014 coef_commit in PENDING SHALL be ignored.
REQ-015 coef_commit in FILL SHALL go to PENDING and abandon the fill; out_valid stays low.
REQ-016 If coef_commit and coef_wr_en are high in the same cycle in IDLE, the write SHALL land before the snapshot.
REQ-017 If coef_commit is high while count==DIV-1, the swap SHALL wait for the next wrap, i.e. at least one full sample.
REQ-018 coef_active SHALL change only on commit_ack cycles, so the filter never sees a mixed bank.

Reset
REQ-019 While reset is high, on each edge:
- counter = 0, phase = 0
- state = FILL with the fill count cleared
- out_valid = 0, commit_ack = 0, wr_err = 0
- sam_clk_en = 0, sys_clk2_en = 0
REQ-020 On reset, both banks SHALL load the defaults {-348, 0, 3274, 0, -15925, 0, 78535, 131072} for indices 0..7.
REQ-021 Reset during PENDING SHALL discard the pending commit; shadow contents also return to the defaults.
REQ-022 Strobes SHALL resume at count==DIV/2-1, DIV/2 cycles after reset deasserts.

Structure
REQ-023 A shared package SHALL hold the default-coefficient constant array, the FSM state enum and the WIDTH/NCOEF defaults.
REQ-024 The divider and strobe generation SHALL live in one sub-module, halfband_strobe_gen; the bank and FSM stay in the top module.

Verification
REQ-025 Strobes: with DIV=16, release reset.
- sys_clk2_en pulses at cycles 7, 15, 23, ...
- sam_clk_en pulses at cycles 15, 31, ...
- phase alternates 1, 0, 1, ...
REQ-026 Reset fill: with FILL=5, out_valid rises exactly after the 5th sys_clk2_en (cycle 39), and commit_ack stays 0.
REQ-027 Commit: write shadow[7]=65536, then commit at count 3.
- coef_active[7] stays 131072 until count 15.
- At count 15, commit_ack=1 and the value becomes 65536.
- out_valid is low for 5 strobes.
REQ-028 Write while pending: commit, then write addr 2 = 100 before the swap.
- wr_err pulses.
- After the swap, index 2 is still 3274.
REQ-029 Boundary commit: commit at count==15; the swap occurs at the following count==15, 16 cycles later.
REQ-030 Reset mid-PENDING: no commit_ack, coef_active equals the defaults, and out_valid returns per REQ-026.
